sdram_scan_viewer: RTL and testbench
====================================

// Module: sdram_scan_viewer
// PURPOSE
//  Parametrised readback viewer for the SDRAM loader path. On START it reads NUM_WORDS words from BASE_ADDR upward
//  over a req/ack/valid read port, and shows each word on the HEX digits plus LEDR.
//  In auto mode each word is held for DWELL_CYCLES; in manual mode the word advances on each STEP pulse.
//  Adds scanning, looping, a read timeout and status flags. The current top shows only one 32-bit word.
// PARAMETERS
//  DATA_W         32          read word width (>=8); bits [7:0] go to LEDR, bits [DATA_W-1:8] go to the HEX digits
//  ADDR_W         25          read address width
//  BASE_ADDR      0           first word address
//  NUM_WORDS      16          words per scan (>=1)
//  NUM_DIGITS     6           hex digits driven; upper data is zero-extended/truncated to NUM_DIGITS*4 bits
//  DWELL_CYCLES   50_000_000  auto-mode hold time per word (1 s at 50 MHz)
//  TIMEOUT_CYCLES 1024        max cycles from entering REQ to RD_VALID
//  LOOP           1           1: auto mode wraps to word 0 after last word; 0: stop in DONE
// PORTS
//  MAX10_CLK1_50  in   1             clock; all logic on rising edge
//  RST            in   1             synchronous, active-high reset
//  START          in   1             1-cycle pulse; begins a scan; ignored while BUSY
//  MODE           in   1             0 = auto dwell, 1 = manual STEP; sampled when START is accepted
//  STEP           in   1             1-cycle pulse; advance word in manual mode
//  RD_REQ         out  1             read request
//  RD_ADDR        out  ADDR_W        read address; stable while RD_REQ=1
//  RD_ACK         in   1             request accepted this cycle
//  RD_VALID       in   1             RD_DATA valid this cycle
//  RD_DATA        in   DATA_W        read data
//  SEG            out  NUM_DIGITS*8  active-low 7-seg+DP; digit k = SEG[8k+7:8k]; bit 7 = DP
//  LEDR           out  10            [7:0] = word[7:0]; [8] = TIMEOUT_ERR; [9] = BUSY
//  BUSY           out  1             scan in progress (states REQ, WAIT, SHOW)
//  DONE           out  1             non-looping scan finished; sticky until START or RST
//  TIMEOUT_ERR    out  1             read timed out; sticky until START or RST
// BEHAVIOUR
//  Reset: state=IDLE, index=0, RD_REQ=0, RD_ADDR=BASE_ADDR, shown word=0, SEG all 8'hFF (blank), LEDR=0,
//    BUSY/DONE/TIMEOUT_ERR=0. RST has priority over every other input. RST mid-scan aborts; RD_REQ=0 after that edge.
//  Index/address: RD_ADDR = BASE_ADDR + index.
//    index runs 0..NUM_WORDS-1; in LOOP auto mode index wraps from NUM_WORDS-1 to 0.
//  FSM:
//    IDLE/DONE: on START -> REQ; index=0; clear DONE and TIMEOUT_ERR; latch MODE.
//    REQ: RD_REQ=1. If RD_ACK=1 -> WAIT, and RD_REQ=0 from the next cycle.
//    WAIT: on the first RD_VALID, latch RD_DATA as the shown word -> SHOW, and load the dwell counter.
//      RD_VALID outside WAIT is ignored.
//    Timeout: a counter starts at 0 on entry to REQ. If TIMEOUT_CYCLES elapse without RD_VALID -> DONE,
//      with TIMEOUT_ERR=1, RD_REQ=0 and the shown word unchanged.
//    SHOW, auto mode: when the dwell count expires -> next word. Manual mode: STEP -> next word; STEP in other states is ignored.
//      next word, not last: index+1 -> REQ.
//      next word, last, auto mode, LOOP=1: index=0 -> REQ.
//      next word, last, otherwise: -> DONE with DONE=1.
//    Manual mode never loops.
//  Display: hex digit k shows nibble k of word[DATA_W-1:8], using standard active-low hex glyphs (0=7'h40 ... F=7'h0E).
//    DP (bit 7) is driven 0 (lit) only on digit NUM_DIGITS-1, and only while the shown word is index NUM_WORDS-1.
//    SEG stays blank until the first word is latched after reset.
//    Outputs are registered, so SEG and LEDR update 1 cycle after the RD_VALID capture.
//  Latency: START -> RD_REQ=1 takes 1 cycle. With zero-wait ack/valid, START -> SEG update takes 4 cycles.
//  START and STEP arriving in the same cycle in SHOW: STEP applies; START is ignored because BUSY=1.
// TESTING
//  T1: DWELL_CYCLES=4, NUM_WORDS=3, LOOP=0, memory returns addr*0x01010101, START with MODE=0
//    -> SEG/LEDR show 0x00000000, 0x01010101, 0x02020202 in order; DONE=1 after word 2.
//  T2: LOOP=1, NUM_WORDS=2, auto mode -> RD_ADDR sequence BASE, BASE+1, BASE, BASE+1; DONE stays 0.
//  T3: MODE=1 -> no second request until a STEP pulse; a STEP while in WAIT is ignored; DP on top digit lit on last word.
//  T4: RD_VALID never asserted, TIMEOUT_CYCLES=8 -> TIMEOUT_ERR=1 and LEDR[8]=1 exactly 8 cycles after REQ entry; a new START clears it.
//  T5: RST asserted while in WAIT -> next cycle all outputs at reset values; a later RD_VALID causes no update.
//  T6: RD_ACK held low for 5 cycles -> RD_REQ and RD_ADDR stay stable throughout; START during the scan has no effect.

Source files
------------

// File: rtl/sdram_scan_viewer.sv
// Readback viewer: scans NUM_WORDS words over a req/ack/valid read port and
// shows each word on the hex digits and LEDR, auto-dwell or manual-step.
module sdram_scan_viewer #(
   parameter int          DATA_W         = 32,
   parameter int          ADDR_W         = 25,
   parameter int unsigned BASE_ADDR      = 0,
   parameter int          NUM_WORDS      = 16,
   parameter int          NUM_DIGITS     = 6,
   parameter int          DWELL_CYCLES   = 50_000_000,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter int          LOOP           = 1
) (
   input  logic                    MAX10_CLK1_50,
   input  logic                    RST,
   input  logic                    START,
   input  logic                    MODE,
   input  logic                    STEP,
   output logic                    RD_REQ,
   output logic [ADDR_W-1:0]       RD_ADDR,
   input  logic                    RD_ACK,
   input  logic                    RD_VALID,
   input  logic [DATA_W-1:0]       RD_DATA,
   output logic [NUM_DIGITS*8-1:0] SEG,
   output logic [9:0]              LEDR,
   output logic                    BUSY,
   output logic                    DONE,
   output logic                    TIMEOUT_ERR
);

   localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int DW_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int HEX_W = NUM_DIGITS * 4;
   localparam int HI_W  = DATA_W - 8;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [DW_W-1:0]  DW_LOAD  = DW_W'(DWELL_CYCLES - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_SHOW = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]              state_q,  state_d;
   logic [IDX_W-1:0]        index_q,  index_d;
   logic                    mode_q,   mode_d;
   logic [DATA_W-1:0]       word_q,   word_d;
   logic                    shown_q,  shown_d;
   logic                    last_q,   last_d;
   logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
   logic [DW_W-1:0]         dw_cnt_q, dw_cnt_d;
   logic                    done_q,   done_d;
   logic                    terr_q,   terr_d;
   logic [NUM_DIGITS*8-1:0] seg_q,    seg_d;
   logic [7:0]              led_q,    led_d;
   logic                    advance;

   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      case (n)
         4'h0: hex_glyph = 7'h40;
         4'h1: hex_glyph = 7'h79;
         4'h2: hex_glyph = 7'h24;
         4'h3: hex_glyph = 7'h30;
         4'h4: hex_glyph = 7'h19;
         4'h5: hex_glyph = 7'h12;
         4'h6: hex_glyph = 7'h02;
         4'h7: hex_glyph = 7'h78;
         4'h8: hex_glyph = 7'h00;
         4'h9: hex_glyph = 7'h10;
         4'hA: hex_glyph = 7'h08;
         4'hB: hex_glyph = 7'h03;
         4'hC: hex_glyph = 7'h46;
         4'hD: hex_glyph = 7'h21;
         4'hE: hex_glyph = 7'h06;
         default: hex_glyph = 7'h0E;
      endcase
   endfunction

   always_comb begin
      state_d  = state_q;
      index_d  = index_q;
      mode_d   = mode_q;
      word_d   = word_q;
      shown_d  = shown_q;
      last_d   = last_q;
      to_cnt_d = to_cnt_q;
      dw_cnt_d = dw_cnt_q;
      done_d   = done_q;
      terr_d   = terr_q;
      advance  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (START) begin
               state_d  = S_REQ;
               index_d  = '0;
               done_d   = 1'b0;
               terr_d   = 1'b0;
               mode_d   = MODE;
               to_cnt_d = '0;
            end
         end
         S_REQ, S_WAIT: begin
            // A capture on the final allowed cycle still wins over the timeout.
            if (state_q == S_WAIT && RD_VALID) begin
               word_d   = RD_DATA;
               shown_d  = 1'b1;
               last_d   = (index_q == LAST_IDX);
               dw_cnt_d = DW_LOAD;
               state_d  = S_SHOW;
            end else if (to_cnt_q == TO_LAST) begin
               state_d = S_DONE;
               terr_d  = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
               if (state_q == S_REQ && RD_ACK) begin
                  state_d = S_WAIT;
               end
            end
         end
         S_SHOW: begin
            advance = mode_q ? STEP : (dw_cnt_q == '0);
            if (!advance && !mode_q) begin
               dw_cnt_d = dw_cnt_q - DW_W'(1);
            end
            if (advance) begin
               if (index_q != LAST_IDX) begin
                  index_d  = index_q + IDX_W'(1);
                  state_d  = S_REQ;
                  to_cnt_d = '0;
               end else if (!mode_q && LOOP != 0) begin
                  index_d  = '0;
                  state_d  = S_REQ;
                  to_cnt_d = '0;
               end else begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Upper data zero-extended or truncated to the digit field width.
   logic [HEX_W-1:0] hex_bits;
   generate
      for (genvar gi = 0; gi < HEX_W; gi++) begin : g_hex_bits
         if (gi < HI_W) begin : g_data
            assign hex_bits[gi] = word_q[8+gi];
         end else begin : g_zero
            assign hex_bits[gi] = 1'b0;
         end
      end
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign seg_d[8*gi +: 8] = shown_q ?
            {((gi == NUM_DIGITS - 1) ? ~last_q : 1'b1), hex_glyph(hex_bits[4*gi +: 4])} : 8'hFF;
      end
   endgenerate

   assign led_d = word_q[7:0];

   always_ff @(posedge MAX10_CLK1_50) begin
      if (RST) begin
         state_q  <= S_IDLE;
         index_q  <= '0;
         mode_q   <= 1'b0;
         word_q   <= '0;
         shown_q  <= 1'b0;
         last_q   <= 1'b0;
         to_cnt_q <= '0;
         dw_cnt_q <= '0;
         done_q   <= 1'b0;
         terr_q   <= 1'b0;
         seg_q    <= '1;
         led_q    <= '0;
      end else begin
         state_q  <= state_d;
         index_q  <= index_d;
         mode_q   <= mode_d;
         word_q   <= word_d;
         shown_q  <= shown_d;
         last_q   <= last_d;
         to_cnt_q <= to_cnt_d;
         dw_cnt_q <= dw_cnt_d;
         done_q   <= done_d;
         terr_q   <= terr_d;
         seg_q    <= seg_d;
         led_q    <= led_d;
      end
   end

   assign RD_REQ      = (state_q == S_REQ);
   assign RD_ADDR     = ADDR_W'(BASE_ADDR) + ADDR_W'(index_q);
   assign BUSY        = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_SHOW);
   assign DONE        = done_q;
   assign TIMEOUT_ERR = terr_q;
   assign SEG         = seg_q;
   // Status bits bypass the display register so they track the flags directly.
   assign LEDR        = {BUSY, terr_q, led_q};

endmodule

// File: tb/tb_sdram_scan_viewer.sv
// Bench for sdram_scan_viewer: a memory model with adjustable ack/valid delay,
// a word scoreboard for SEG/LEDR, and a second looping instance for address order.
module tb_sdram_scan_viewer;

   typedef struct {
      int          due;
      logic [47:0] seg;
      logic [7:0]  led;
      int          addr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1, start = 1'b0, mode = 1'b0, step = 1'b0;

   logic        req_a, ack_a, busy_a, done_a, terr_a;
   logic        valid_a = 1'b0;
   logic [31:0] data_a = '0;
   logic [24:0] addr_a;
   logic [47:0] seg_a;
   logic [9:0]  ledr_a;

   logic        req_b, ack_b, busy_b, done_b, terr_b;
   logic        valid_b = 1'b0;
   logic [31:0] data_b = '0;
   logic [24:0] addr_b;
   logic [47:0] seg_b;
   logic [9:0]  ledr_b;

   int   errors = 0, checks = 0, cyc = 0;
   int   hold_n = 0, valid_dly = 0, wait_cnt = 0, valid_pulses = 0;
   logic valid_en = 1'b1, sb_push_en = 1'b1, pend = 1'b0;
   int   pend_addr = 0;
   int   req_cycles_q = 0;
   logic acc_a_q = 1'b0, acc_b_q = 1'b0;
   logic [24:0] addr_a_q = '0, addr_b_q = '0;
   int   acks_a[$], acks_b[$];
   exp_t sb[$];

   always #5 clk = ~clk;

   sdram_scan_viewer #(.DATA_W(32), .ADDR_W(25), .BASE_ADDR(0), .NUM_WORDS(3), .NUM_DIGITS(6),
                       .DWELL_CYCLES(4), .TIMEOUT_CYCLES(8), .LOOP(0)) dut_a (
      .MAX10_CLK1_50(clk), .RST(rst), .START(start), .MODE(mode), .STEP(step),
      .RD_REQ(req_a), .RD_ADDR(addr_a), .RD_ACK(ack_a), .RD_VALID(valid_a), .RD_DATA(data_a),
      .SEG(seg_a), .LEDR(ledr_a), .BUSY(busy_a), .DONE(done_a), .TIMEOUT_ERR(terr_a));

   sdram_scan_viewer #(.DATA_W(32), .ADDR_W(25), .BASE_ADDR(5), .NUM_WORDS(2), .NUM_DIGITS(6),
                       .DWELL_CYCLES(4), .TIMEOUT_CYCLES(8), .LOOP(1)) dut_b (
      .MAX10_CLK1_50(clk), .RST(rst), .START(start), .MODE(mode), .STEP(step),
      .RD_REQ(req_b), .RD_ADDR(addr_b), .RD_ACK(ack_b), .RD_VALID(valid_b), .RD_DATA(data_b),
      .SEG(seg_b), .LEDR(ledr_b), .BUSY(busy_b), .DONE(done_b), .TIMEOUT_ERR(terr_b));

   assign ack_a = req_a && (req_cycles_q >= hold_n);
   assign ack_b = req_b;

   always @(posedge clk) begin
      acc_a_q      <= req_a && ack_a;
      addr_a_q     <= addr_a;
      req_cycles_q <= (req_a && !ack_a) ? req_cycles_q + 1 : 0;
      if (req_a && ack_a) acks_a.push_back(int'(addr_a));
      acc_b_q  <= req_b && ack_b;
      addr_b_q <= addr_b;
      if (req_b && ack_b) acks_b.push_back(int'(addr_b));
   end

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
      endcase
   endfunction

   function automatic logic [47:0] exp_seg(input logic [31:0] w, input logic last);
      logic [47:0] r;
      for (int k = 0; k < 6; k++) begin
         r[8*k +: 8] = {(k == 5 && last) ? 1'b0 : 1'b1, glyph(w[8+4*k +: 4])};
      end
      return r;
   endfunction

   function automatic logic [31:0] mem_word(input int addr);
      return 32'(addr) * 32'h01010101;
   endfunction

   // One negedge: compare due scoreboard entries, then drive both memory models.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      cyc++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         checks++;
         if (seg_a !== e.seg || ledr_a[7:0] !== e.led) begin
            errors++;
            $display("FAIL sb_word addr=%0d seg=%h led=%h expected seg=%h led=%h",
                     e.addr, seg_a, ledr_a[7:0], e.seg, e.led);
         end else begin
            $display("word addr=%0d seg=%h led=%h", e.addr, seg_a, ledr_a[7:0]);
         end
      end
      valid_a = 1'b0;
      if (acc_a_q && valid_en) begin
         pend      = 1'b1;
         wait_cnt  = valid_dly;
         pend_addr = int'(addr_a_q);
      end
      if (pend) begin
         if (wait_cnt == 0) begin
            valid_a = 1'b1;
            data_a  = mem_word(pend_addr);
            pend    = 1'b0;
            valid_pulses++;
            if (sb_push_en) begin
               e.due  = cyc + 2;
               e.seg  = exp_seg(data_a, pend_addr == 2);
               e.led  = data_a[7:0];
               e.addr = pend_addr;
               sb.push_back(e);
            end
         end else begin
            wait_cnt--;
         end
      end
      valid_b = acc_b_q;
      data_b  = mem_word(int'(addr_b_q));
   endtask

   task automatic pulse_start(input logic m);
      mode  = m;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_step();
      step = 1'b1;
      tick();
      step = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int k = 0; k < 200 && !(done_a && sb.size() == 0); k++) tick();
      checks++;
      if (done_a !== 1'b1 || sb.size() != 0) begin
         errors++;
         $display("FAIL %s_done done=%b pending=%0d required done=1 pending=0", name, done_a, sb.size());
      end
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL rst_req got=%b want=0", req_a); end
      checks++; if (addr_a !== 25'd0) begin errors++; $display("FAIL rst_addr got=%h want=0", addr_a); end
      checks++; if (seg_a !== {48{1'b1}}) begin errors++; $display("FAIL rst_seg got=%h want=all ones", seg_a); end
      checks++; if (ledr_a !== 10'd0) begin errors++; $display("FAIL rst_ledr got=%h want=0", ledr_a); end
      checks++;
      if ({busy_a, done_a, terr_a} !== 3'b000) begin
         errors++; $display("FAIL rst_flags got=%b want=000", {busy_a, done_a, terr_a});
      end
      checks++; if (addr_b !== 25'd5) begin errors++; $display("FAIL rst_addr_b got=%h want=5", addr_b); end
      rst = 1'b0;
      tick();
      $display("reset checked");
   endtask

   task automatic test_auto_scan();
      int n0 = acks_a.size();
      pulse_start(1'b0);
      checks++; if (req_a !== 1'b1) begin errors++; $display("FAIL start_req_latency got=%b want=1", req_a); end
      tick();
      tick();
      checks++; if (seg_a !== {48{1'b1}}) begin errors++; $display("FAIL seg_early got=%h want=blank", seg_a); end
      tick();
      checks++;
      if (seg_a !== exp_seg(32'h0, 1'b0)) begin
         errors++; $display("FAIL seg_latency4 got=%h want=%h", seg_a, exp_seg(32'h0, 1'b0));
      end
      wait_done("auto");
      checks++;
      if (acks_a.size() != n0 + 3 || acks_a[n0] != 0 || acks_a[n0+1] != 1 || acks_a[n0+2] != 2) begin
         errors++; $display("FAIL auto_addr_seq count=%0d want 3 addresses 0,1,2", acks_a.size() - n0);
      end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL auto_busy got=%b want=0", busy_a); end
      $display("auto scan finished at cycle %0d", cyc);
   endtask

   task automatic test_loop();
      for (int k = 0; k < 200 && acks_b.size() < 4; k++) tick();
      checks++;
      if (acks_b.size() < 4 || acks_b[0] != 5 || acks_b[1] != 6 || acks_b[2] != 5 || acks_b[3] != 6) begin
         errors++; $display("FAIL loop_addr_seq count=%0d want 5,6,5,6", acks_b.size());
      end
      checks++;
      if (done_b !== 1'b0 || busy_b !== 1'b1) begin
         errors++; $display("FAIL loop_flags done=%b busy=%b want done=0 busy=1", done_b, busy_b);
      end
      $display("loop sequence checked, %0d requests", acks_b.size());
   endtask

   task automatic test_manual();
      int n0 = acks_a.size();
      pulse_start(1'b1);
      repeat (12) tick();
      checks++;
      if (acks_a.size() != n0 + 1 || req_a !== 1'b0 || busy_a !== 1'b1) begin
         errors++; $display("FAIL manual_hold reqs=%0d req=%b busy=%b want reqs=1 req=0 busy=1",
                            acks_a.size() - n0, req_a, busy_a);
      end
      pulse_step();
      valid_dly = 2;
      tick();
      tick();
      pulse_step();
      repeat (15) tick();
      valid_dly = 0;
      checks++;
      if (acks_a.size() != n0 + 2 || sb.size() != 0) begin
         errors++; $display("FAIL manual_wait_step reqs=%0d want=2", acks_a.size() - n0);
      end
      pulse_step();
      repeat (10) tick();
      checks++;
      if (seg_a[47] !== 1'b0 || seg_a[39] !== 1'b1) begin
         errors++; $display("FAIL manual_dp top=%b next=%b want top=0 next=1", seg_a[47], seg_a[39]);
      end
      pulse_step();
      tick();
      checks++;
      if (done_a !== 1'b1 || busy_a !== 1'b0 || acks_a.size() != n0 + 3) begin
         errors++; $display("FAIL manual_end done=%b busy=%b reqs=%0d want done=1 busy=0 reqs=3",
                            done_a, busy_a, acks_a.size() - n0);
      end
      $display("manual scan finished at cycle %0d", cyc);
   endtask

   task automatic test_timeout();
      logic [47:0] seg_before = seg_a;
      valid_en = 1'b0;
      pulse_start(1'b0);
      repeat (7) tick();
      checks++; if (terr_a !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b want=0", terr_a); end
      tick();
      checks++;
      if (terr_a !== 1'b1 || ledr_a[8] !== 1'b1) begin
         errors++; $display("FAIL timeout_flag err=%b ledr8=%b want 1,1", terr_a, ledr_a[8]);
      end
      checks++;
      if (req_a !== 1'b0 || busy_a !== 1'b0 || seg_a !== seg_before) begin
         errors++; $display("FAIL timeout_state req=%b busy=%b seg=%h want req=0 busy=0 seg=%h",
                            req_a, busy_a, seg_a, seg_before);
      end
      valid_en = 1'b1;
      pulse_start(1'b0);
      checks++;
      if (terr_a !== 1'b0 || ledr_a[8] !== 1'b0 || busy_a !== 1'b1) begin
         errors++; $display("FAIL timeout_clear err=%b ledr8=%b busy=%b want 0,0,1", terr_a, ledr_a[8], busy_a);
      end
      wait_done("after_timeout");
      $display("timeout checked at cycle %0d", cyc);
   endtask

   task automatic test_ack_stall();
      int n0 = acks_a.size();
      int bad = 0;
      hold_n = 5;
      pulse_start(1'b0);
      for (int i = 0; i < 5; i++) begin
         if (req_a !== 1'b1 || addr_a !== 25'd0) bad++;
         start = (i == 2);
         tick();
      end
      start = 1'b0;
      checks++;
      if (bad != 0 || acks_a.size() != n0) begin
         errors++; $display("FAIL stall_stable bad_cycles=%0d early_acks=%0d want 0,0", bad, acks_a.size() - n0);
      end
      for (int k = 0; k < 100 && acks_a.size() < n0 + 2; k++) tick();
      pulse_start(1'b0);
      wait_done("stall");
      hold_n = 0;
      checks++;
      if (acks_a.size() != n0 + 3 || acks_a[n0] != 0 || acks_a[n0+1] != 1 || acks_a[n0+2] != 2) begin
         errors++; $display("FAIL stall_addr_seq count=%0d want 3 addresses 0,1,2", acks_a.size() - n0);
      end
      $display("ack stall checked at cycle %0d", cyc);
   endtask

   task automatic test_reset_abort();
      int n0 = acks_a.size();
      int vp0 = valid_pulses;
      valid_dly  = 3;
      sb_push_en = 1'b0;
      pulse_start(1'b0);
      for (int k = 0; k < 20 && acks_a.size() == n0; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (req_a !== 1'b0 || addr_a !== 25'd0 || seg_a !== {48{1'b1}} || ledr_a !== 10'd0) begin
         errors++; $display("FAIL abort_outputs req=%b addr=%h seg=%h ledr=%h want 0,0,blank,0",
                            req_a, addr_a, seg_a, ledr_a);
      end
      checks++;
      if ({busy_a, done_a, terr_a} !== 3'b000) begin
         errors++; $display("FAIL abort_flags got=%b want=000", {busy_a, done_a, terr_a});
      end
      for (int k = 0; k < 20 && valid_pulses == vp0; k++) tick();
      repeat (3) tick();
      checks++;
      if (valid_pulses == vp0 || seg_a !== {48{1'b1}} || ledr_a !== 10'd0 || busy_a !== 1'b0) begin
         errors++; $display("FAIL abort_late_valid pulses=%0d seg=%h ledr=%h busy=%b want blank,0,0",
                            valid_pulses - vp0, seg_a, ledr_a, busy_a);
      end
      valid_dly  = 0;
      sb_push_en = 1'b1;
      $display("reset abort checked at cycle %0d", cyc);
   endtask

   initial begin
      test_reset();
      test_auto_scan();
      test_loop();
      test_manual();
      test_timeout();
      test_ack_stall();
      test_reset_abort();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL sb_leftover pending=%0d want=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
